lcd_3wire_serial_engine: RTL and testbench

- Serial back-end for the LTM panel configuration path. It consumes 16-bit register words (6-bit address, 2-bit control, 8-bit data) from the LUT-driven configuration sequencer and shifts them out MSB-first on the panel's 3-wire bus (SCEN/SCLK/SDA).
- It also generates the slow clock that the sequencer runs on.
- The str/rdy/ack handshake lets the sequencer issue one register write per transaction.

---
 rtl/lcd_3wire_serial_engine.sv | 145 ++++++++++++++
 tb/tb_lcd_3wire_serial_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_3wire_serial_engine.sv
// 3-wire (SCEN/SCLK/SDA) serial back-end for LTM panel register writes.
// Also divides iCLK to produce the slow clock the configuration sequencer runs on.
`timescale 1ns/1ps
module lcd_3wire_serial_engine #(
    parameter int unsigned CLK_DIV = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [15:0] iDATA,
    input  logic        iSTR,
    output logic        oACK,
    output logic        oRDY,
    output logic        oCLK,
    output logic        oSCEN,
    inout  wire         SDA,
    output logic        oSCLK
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_END,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mclk_q, mclk_d;
    logic [15:0]       sr_q, sr_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic              scen_q, scen_d;
    logic              sclk_q, sclk_d;
    logic              sda_q, sda_d;
    logic              ack_q, ack_d;
    logic              rdy_q, rdy_d;
    logic              tick;
    logic              step;

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));
    // FSM steps on the mclk falling tick, half a sequencer cycle after its posedge.
    assign step = tick & mclk_q;

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        mclk_d   = mclk_q ^ tick;
        state_d  = state_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        scen_d   = scen_q;
        sclk_d   = sclk_q;
        sda_d    = sda_q;
        ack_d    = ack_q;
        rdy_d    = rdy_q;
        if (step) begin
            case (state_q)
                S_IDLE: begin
                    scen_d = 1'b1;
                    sclk_d = 1'b1;
                    rdy_d  = 1'b0;
                    if (iSTR) begin
                        sr_d     = iDATA;
                        bitcnt_d = 4'd15;
                        ack_d    = 1'b0;
                        scen_d   = 1'b0;
                        state_d  = S_LOW;
                    end
                end
                S_LOW, S_HIGH: begin
                    if (!iSTR) begin
                        scen_d  = 1'b1;
                        sclk_d  = 1'b1;
                        ack_d   = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = S_WAIT;
                    end else if (state_q == S_LOW) begin
                        sclk_d  = 1'b0;
                        sda_d   = sr_q[15];
                        state_d = S_HIGH;
                    end else begin
                        // sda_q is a separate flop so the shift here cannot disturb
                        // the bit the panel samples on this rising edge.
                        sclk_d = 1'b1;
                        if (bitcnt_q == 4'd0) begin
                            state_d = S_END;
                        end else begin
                            sr_d     = {sr_q[14:0], 1'b0};
                            bitcnt_d = bitcnt_q - 4'd1;
                            state_d  = S_LOW;
                        end
                    end
                end
                S_END: begin
                    scen_d  = 1'b1;
                    sclk_d  = 1'b1;
                    ack_d   = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (!iSTR) begin
                        rdy_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mclk_q   <= 1'b0;
            sr_q     <= '0;
            bitcnt_q <= '0;
            scen_q   <= 1'b1;
            sclk_q   <= 1'b1;
            sda_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mclk_q   <= mclk_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            scen_q   <= scen_d;
            sclk_q   <= sclk_d;
            sda_q    <= sda_d;
            ack_q    <= ack_d;
            rdy_q    <= rdy_d;
        end
    end

    assign oCLK  = mclk_q;
    assign oSCEN = scen_q;
    assign oSCLK = sclk_q;
    assign oACK  = ack_q;
    assign oRDY  = rdy_q;
    assign SDA   = scen_q ? 1'bz : sda_q;

endmodule

// File: tb/tb_lcd_3wire_serial_engine.sv
// Scoreboard bench for lcd_3wire_serial_engine: a driver issues register writes,
// a monitor reassembles SDA bits at SCLK rises and checks them against the queue.
`timescale 1ns/1ps
module tb_lcd_3wire_serial_engine;

    localparam int DIV = 2;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic [15:0] iDATA = '0;
    logic        iSTR = 1'b0;
    logic        oACK, oRDY, oCLK, oSCEN, oSCLK;
    wire         SDA;

    pullup (SDA);

    lcd_3wire_serial_engine #(.CLK_DIV(DIV), .CNT_W(8)) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iDATA  (iDATA),
        .iSTR   (iSTR),
        .oACK   (oACK),
        .oRDY   (oRDY),
        .oCLK   (oCLK),
        .oSCEN  (oSCEN),
        .SDA    (SDA),
        .oSCLK  (oSCLK)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic        ack;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          rx_cnt = 0;
    int          rx_frame = 0;
    logic [15:0] rx_word = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: rebuild the frame the panel would see, compare on each oRDY rise.
    initial begin
        logic prev_scen, prev_sclk, prev_rdy;
        exp_t e;
        prev_scen = 1'b1; prev_sclk = 1'b1; prev_rdy = 1'b0;
        forever begin
            @(negedge iCLK);
            if (!iRST_n) begin
                rx_cnt = 0;
                rx_word = '0;
            end else begin
                if (prev_scen && !oSCEN) begin
                    rx_cnt = 0;
                    rx_word = '0;
                    rx_frame++;
                end
                if (!prev_sclk && oSCLK && !oSCEN) begin
                    rx_word = {rx_word[14:0], SDA};
                    rx_cnt++;
                end
                if (!prev_rdy && oRDY) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL rdy_unexpected: got oRDY=1 expected no pending transfer");
                    end else begin
                        e = sb.pop_front();
                        check("ack", int'(oACK), int'(e.ack));
                        check("scen_at_rdy", int'(oSCEN), 1);
                        check("nbits", rx_cnt, e.nbits);
                        check("word", int'(rx_word), int'(e.word >> (16 - e.nbits)));
                    end
                end
            end
            prev_scen = oSCEN;
            prev_sclk = oSCLK;
            prev_rdy  = oRDY;
        end
    end

    task automatic finish_handshake();
        int budget;
        budget = 40 * 2 * DIV;
        while (!oRDY && budget > 0) begin @(negedge iCLK); budget--; end
        check("rdy_timeout", int'(budget > 0), 1);
        if (iSTR) begin
            @(posedge oCLK); #1;
            iSTR = 1'b0;
        end
        budget = 2 * DIV + 2;
        while (oRDY && budget > 0) begin @(negedge iCLK); budget--; end
        check("rdy_drop", int'(oRDY), 0);
        check("scen_idle", int'(oSCEN), 1);
        check("sclk_idle", int'(oSCLK), 1);
    endtask

    // abort_at==0: full transfer; otherwise drop iSTR after that many SCLK rises.
    task automatic do_xfer(input logic [15:0] word, input int abort_at, input logic [15:0] late);
        exp_t e;
        int   k, budget, target;
        @(posedge oCLK); #1;
        iDATA = word;
        iSTR  = 1'b1;
        e.word  = word;
        e.nbits = (abort_at == 0) ? 16 : abort_at;
        e.ack   = (abort_at == 0);
        sb.push_back(e);
        target = rx_frame + 1;
        k = (abort_at == 0) ? 3 : abort_at;
        budget = 40 * 2 * DIV;
        while (!(rx_frame == target && rx_cnt >= k) && budget > 0) begin
            @(negedge iCLK); budget--;
        end
        check("bits_timeout", int'(budget > 0), 1);
        iDATA = late;
        if (abort_at != 0) iSTR = 1'b0;
        finish_handshake();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int budget;
        logic prev;
        logic [15:0] w;
        int a;

        repeat (3) @(negedge iCLK);
        check("rst_oclk", int'(oCLK), 0);
        check("rst_scen", int'(oSCEN), 1);
        check("rst_sclk", int'(oSCLK), 1);
        check("rst_sda_released", int'(SDA), 1);
        check("rst_rdy", int'(oRDY), 0);
        check("rst_ack", int'(oACK), 0);
        iRST_n = 1'b1;

        // Divider: oCLK half-period must be DIV iCLK cycles.
        budget = 4 * DIV;
        prev = oCLK;
        while (oCLK == prev && budget > 0) begin @(negedge iCLK); budget--; end
        check("oclk_start", int'(budget > 0), 1);
        for (int i = 0; i < 4; i++) begin
            prev = oCLK;
            cnt = 0;
            while (oCLK == prev && cnt < 4 * DIV) begin @(negedge iCLK); cnt++; end
            check("oclk_halfperiod", cnt, DIV);
        end
        check("idle_rdy", int'(oRDY), 0);

        do_xfer(16'h4505, 0, 16'hFFFF);
        do_xfer(16'h8DFF, 0, 16'h0000);
        do_xfer(16'h4505, 5, 16'hA5A5);

        for (int i = 0; i < 12; i++) begin
            w = 16'($urandom);
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
            do_xfer(w, a, 16'($urandom));
        end

        // Reset in the middle of a frame.
        @(posedge oCLK); #1;
        iDATA = 16'($urandom);
        iSTR  = 1'b1;
        budget = 40 * 2 * DIV;
        cnt = rx_frame + 1;
        while (!(rx_frame == cnt && rx_cnt >= 8) && budget > 0) begin
            @(negedge iCLK); budget--;
        end
        check("mid_frame_reached", int'(budget > 0), 1);
        iRST_n = 1'b0;
        #1;
        check("mrst_scen", int'(oSCEN), 1);
        check("mrst_sclk", int'(oSCLK), 1);
        check("mrst_sda_released", int'(SDA), 1);
        check("mrst_rdy", int'(oRDY), 0);
        iSTR = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_n = 1'b1;
        do_xfer(16'h1234, 0, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
